// File: rtl/lcd_line_reader.sv
// ---------------------------------------------------------------------------
// lcd_line_reader
//   Read side of the LCD text-line buffer. Walks the 1bpp line RAM (240 px x
//   16 rows, 480 bytes) in ascending address order. Each bit becomes one
//   RGB565 pixel: the latched foreground colour for a 1, background for a 0.
//   Bits go out MSB first. Pixels are streamed over a valid/ready handshake.
//   One accepted start strobe produces one full band of COL*8 pixels, followed
//   by a one-cycle done pulse.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   start      in   one-cycle strobe; accepted only when idle
//   fg_color   in   colour for bit=1, captured on an accepted start
//   bg_color   in   colour for bit=0, captured on an accepted start
//   addrb      out  RAM read address
//   doutb      in   RAM read data, registered, one-cycle latency
//   ram_wen    in   RAM write enable; a write cancels that cycle's read
//   pix_data   out  pixel value
//   pix_valid  out  pix_data is valid
//   pix_ready  in   sink accepts the pixel when valid & ready
//   busy       out  high from accepted start until the done cycle ends
//   done       out  one-cycle pulse after the last pixel is accepted
// ---------------------------------------------------------------------------
module lcd_line_reader #(
    parameter int DATA_WDTH = 8,
    parameter int COL       = 480,
    parameter int COL_BITS  = 9,
    parameter int BYTES_ROW = 30,
    parameter int PIX_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PIX_W-1:0]     fg_color,
    input  logic [PIX_W-1:0]     bg_color,
    output logic [COL_BITS-1:0]  addrb,
    input  logic [DATA_WDTH-1:0] doutb,
    input  logic                 ram_wen,
    output logic [PIX_W-1:0]     pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 busy,
    output logic                 done
);

    // The band must consist of whole pixel rows.
    if (COL % BYTES_ROW != 0) begin : g_bad_geometry
        $error("lcd_line_reader: COL must be a multiple of BYTES_ROW");
    end

    localparam int BC_W = $clog2(DATA_WDTH);
    localparam logic [COL_BITS-1:0] LAST_ADDR = COL_BITS'(COL - 1);
    localparam logic [BC_W-1:0]     LAST_BIT  = BC_W'(DATA_WDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [DATA_WDTH-1:0] sreg;
    logic [BC_W-1:0]      bit_cnt;
    logic [PIX_W-1:0]     fg_q, bg_q;

    logic xfer;
    logic last_bit;

    assign xfer     = pix_valid & pix_ready;
    assign last_bit = (bit_cnt == LAST_BIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_nxt = state;
        pix_valid = 1'b0;
        pix_data  = '0;
        done      = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = REQ;
            end
            // A write on the same cycle cancels the read; retry the address.
            REQ:  if (!ram_wen) state_nxt = LOAD;
            LOAD: state_nxt = SHIFT;
            SHIFT: begin
                pix_valid = 1'b1;
                pix_data  = sreg[DATA_WDTH-1] ? fg_q : bg_q;
                if (xfer && last_bit)
                    state_nxt = (addrb == LAST_ADDR) ? DONE : REQ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath. pix_data is a pure function of sreg and the colour latches,
    // so it stays stable for as long as a transfer is stalled.
    // NOTE: every datapath register has a defined reset value; there is no
    // storage array here that would need to be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrb   <= '0;
            sreg    <= '0;
            bit_cnt <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        fg_q  <= fg_color;
                        bg_q  <= bg_color;
                        addrb <= '0;
                    end
                end
                LOAD: begin
                    sreg    <= doutb;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    if (xfer) begin
                        sreg    <= sreg << 1;
                        bit_cnt <= bit_cnt + BC_W'(1);
                        if (last_bit && addrb != LAST_ADDR)
                            addrb <= addrb + COL_BITS'(1);
                    end
                end
                DONE:    addrb <= '0;
                default: ;
            endcase
        end
    end

endmodule
